// File: rtl/sw_pkg.sv
// ---------------------------------------------------------------------------
// sw_pkg
// Shared definitions for the Smith-Waterman systolic array:
//   - 2-bit nucleotide symbol encoding
//   - default score width and affine-gap scoring constants
//   - processing-element state encoding
// ---------------------------------------------------------------------------
package sw_pkg;

    // Symbol encoding for query and reference streams.
    localparam logic [1:0] SYM_A = 2'b00;
    localparam logic [1:0] SYM_C = 2'b01;
    localparam logic [1:0] SYM_G = 2'b10;
    localparam logic [1:0] SYM_T = 2'b11;

    // Default score width (unsigned H/E/F/max scores).
    localparam int SCORE_W_DEF  = 12;

    // Default scoring constants.
    localparam int MATCH_DEF    = 2;
    localparam int MISMATCH_DEF = 1;
    localparam int GAP_OPEN_DEF = 2;
    localparam int GAP_EXT_DEF  = 1;

    // PE control states.
    //   ST_IDLE  : no query symbol held, stream passes through unscored
    //   ST_READY : query held, waiting for the first symbol of a stream
    //   ST_RUN   : stream in progress
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READY = 2'd1,
        ST_RUN   = 2'd2
    } pe_state_t;

endpackage

// File: rtl/sw_cell_calc.sv
// ---------------------------------------------------------------------------
// sw_cell_calc
// Combinational affine-gap cell for one Smith-Waterman matrix entry.
//   D = clamp(h_diag + sub)           sub = +MATCH / -MISMATCH
//   E = clamp(max(h_up - GAP_OPEN, e_prev - GAP_EXT))
//   F = clamp(max(h_left - GAP_OPEN, f_left - GAP_EXT))
//   H = max(0, D, E, F)
// All arithmetic is done in SCORE_W+2 signed bits, then clamped to
// [0, 2^SCORE_W-1] so scores saturate instead of wrapping.
//
// Ports:
//   s, t      in   reference and query symbols
//   h_diag    in   H(i-1,j-1)
//   h_up      in   H(i-1,j)  (previous H of this PE)
//   e_prev    in   E(i-1,j)  (previous E of this PE)
//   h_left    in   H(i,j-1)  from the left neighbour
//   f_left    in   F(i,j-1)  from the left neighbour
//   d,e,f,h   out  clamped cell results
// ---------------------------------------------------------------------------
module sw_cell_calc
    import sw_pkg::*;
#(
    parameter int SCORE_W  = SCORE_W_DEF,
    parameter int MATCH    = MATCH_DEF,
    parameter int MISMATCH = MISMATCH_DEF,
    parameter int GAP_OPEN = GAP_OPEN_DEF,
    parameter int GAP_EXT  = GAP_EXT_DEF
) (
    input  logic [1:0]         s,
    input  logic [1:0]         t,
    input  logic [SCORE_W-1:0] h_diag,
    input  logic [SCORE_W-1:0] h_up,
    input  logic [SCORE_W-1:0] e_prev,
    input  logic [SCORE_W-1:0] h_left,
    input  logic [SCORE_W-1:0] f_left,
    output logic [SCORE_W-1:0] d,
    output logic [SCORE_W-1:0] e,
    output logic [SCORE_W-1:0] f,
    output logic [SCORE_W-1:0] h
);

    localparam int CW = SCORE_W + 2;

    localparam logic signed [CW-1:0] MAX_S      = CW'((1 << SCORE_W) - 1);
    localparam logic signed [CW-1:0] MATCH_S    = CW'(MATCH);
    localparam logic signed [CW-1:0] MISMATCH_S = CW'(MISMATCH);
    localparam logic signed [CW-1:0] GO_S       = CW'(GAP_OPEN);
    localparam logic signed [CW-1:0] GE_S       = CW'(GAP_EXT);

    // Zero-extend an unsigned score into the signed working width.
    function automatic logic signed [CW-1:0] ext(input logic [SCORE_W-1:0] x);
        ext = {2'b00, x};
    endfunction

    function automatic logic signed [CW-1:0] smax(input logic signed [CW-1:0] a,
                                                  input logic signed [CW-1:0] b);
        smax = (a > b) ? a : b;
    endfunction

    // Negative values floor at 0; values above the score range saturate.
    function automatic logic [SCORE_W-1:0] clamp(input logic signed [CW-1:0] v);
        if (v[CW-1])
            clamp = '0;
        else if (v > MAX_S)
            clamp = '1;
        else
            clamp = v[SCORE_W-1:0];
    endfunction

    logic signed [CW-1:0] sub;
    logic signed [CW-1:0] d_sum;
    logic signed [CW-1:0] e_sum;
    logic signed [CW-1:0] f_sum;
    logic [SCORE_W-1:0]   de_max;

    always_comb begin
        sub    = (s == t) ? MATCH_S : -MISMATCH_S;
        d_sum  = ext(h_diag) + sub;
        e_sum  = smax(ext(h_up) - GO_S, ext(e_prev) - GE_S);
        f_sum  = smax(ext(h_left) - GO_S, ext(f_left) - GE_S);
        d      = clamp(d_sum);
        e      = clamp(e_sum);
        f      = clamp(f_sum);
        // D/E/F are already floored at 0, so the max with 0 is implicit.
        de_max = (d > e) ? d : e;
        h      = (de_max > f) ? de_max : f;
    end

endmodule

// File: rtl/sw_pe.sv
// ---------------------------------------------------------------------------
// sw_pe
// One processing element of the Smith-Waterman systolic array. Holds one
// query symbol, scores each valid reference symbol against it with an
// affine-gap cell, forwards the registered symbol/H/F to the next PE and
// tracks the maximum H of the current (or most recent) stream.
//
// Handshake: there is no backpressure. valid_i qualifies s_i/h_i/f_i/last_i
// in the cycle it is high; valid_o qualifies s_o/h_o/f_o/last_o exactly one
// cycle later. With valid_i low the PE holds its state and s_o/h_o/f_o.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   load_i, t_i         query symbol load (only in IDLE/READY, valid_i low)
//   valid_i, last_i     input stream qualifier and end-of-stream marker
//   s_i, h_i, f_i       reference symbol and H/F from the left neighbour
//   valid_o, last_o     registered valid_i / last_i
//   s_o, h_o, f_o       registered symbol, H(i,j), F(i,j)
//   max_o               max H of the current/last stream
//   done_o              one-cycle pulse alongside the last output of a stream
//   dbg_state           current control state
// ---------------------------------------------------------------------------
module sw_pe
    import sw_pkg::*;
#(
    parameter int SCORE_W  = SCORE_W_DEF,
    parameter int MATCH    = MATCH_DEF,
    parameter int MISMATCH = MISMATCH_DEF,
    parameter int GAP_OPEN = GAP_OPEN_DEF,
    parameter int GAP_EXT  = GAP_EXT_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load_i,
    input  logic [1:0]         t_i,
    input  logic               valid_i,
    input  logic               last_i,
    input  logic [1:0]         s_i,
    input  logic [SCORE_W-1:0] h_i,
    input  logic [SCORE_W-1:0] f_i,
    output logic               valid_o,
    output logic               last_o,
    output logic [1:0]         s_o,
    output logic [SCORE_W-1:0] h_o,
    output logic [SCORE_W-1:0] f_o,
    output logic [SCORE_W-1:0] max_o,
    output logic               done_o,
    output pe_state_t          dbg_state
);

    pe_state_t          state;
    logic [1:0]         query;
    logic [SCORE_W-1:0] h_diag;
    logic [SCORE_W-1:0] h_up;
    logic [SCORE_W-1:0] e_reg;

    // A stream's first symbol arrives in READY; the carried cell state is
    // forced to 0 there so a stale value can never leak into a new stream.
    logic               first;
    logic [SCORE_W-1:0] h_diag_eff;
    logic [SCORE_W-1:0] h_up_eff;
    logic [SCORE_W-1:0] e_eff;

    logic [SCORE_W-1:0] cell_d;
    logic [SCORE_W-1:0] cell_e;
    logic [SCORE_W-1:0] cell_f;
    logic [SCORE_W-1:0] cell_h;
    logic [SCORE_W-1:0] max_next;

    always_comb begin
        first      = (state == ST_READY);
        h_diag_eff = first ? '0 : h_diag;
        h_up_eff   = first ? '0 : h_up;
        e_eff      = first ? '0 : e_reg;
        max_next   = (first || (cell_h > max_o)) ? cell_h : max_o;
    end

    sw_cell_calc #(
        .SCORE_W  (SCORE_W),
        .MATCH    (MATCH),
        .MISMATCH (MISMATCH),
        .GAP_OPEN (GAP_OPEN),
        .GAP_EXT  (GAP_EXT)
    ) u_cell (
        .s      (s_i),
        .t      (query),
        .h_diag (h_diag_eff),
        .h_up   (h_up_eff),
        .e_prev (e_eff),
        .h_left (h_i),
        .f_left (f_i),
        .d      (cell_d),
        .e      (cell_e),
        .f      (cell_f),
        .h      (cell_h)
    );

    // D is folded into H inside the cell; it is not needed separately here.
    logic unused_d;
    assign unused_d = ^cell_d;

    assign dbg_state = state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_IDLE;
            query   <= SYM_A;
            h_diag  <= '0;
            h_up    <= '0;
            e_reg   <= '0;
            valid_o <= 1'b0;
            last_o  <= 1'b0;
            s_o     <= 2'b00;
            h_o     <= '0;
            f_o     <= '0;
            max_o   <= '0;
            done_o  <= 1'b0;
        end else begin
            valid_o <= valid_i;
            last_o  <= valid_i & last_i;
            done_o  <= 1'b0;
            if (valid_i)
                s_o <= s_i;

            case (state)
                ST_IDLE: begin
                    if (valid_i) begin
                        // No query yet: forward the symbol unscored.
                        h_o <= '0;
                        f_o <= '0;
                    end else if (load_i) begin
                        query <= t_i;
                        state <= ST_READY;
                    end
                end

                ST_READY, ST_RUN: begin
                    if (valid_i) begin
                        h_o   <= cell_h;
                        f_o   <= cell_f;
                        max_o <= max_next;
                        if (last_i) begin
                            h_diag <= '0;
                            h_up   <= '0;
                            e_reg  <= '0;
                            done_o <= 1'b1;
                            state  <= ST_READY;
                        end else begin
                            h_diag <= h_i;
                            h_up   <= cell_h;
                            e_reg  <= cell_e;
                            state  <= ST_RUN;
                        end
                    end else if (load_i && (state == ST_READY)) begin
                        // Reload is allowed only between streams.
                        query <= t_i;
                    end
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sw_pe.sv
// ---------------------------------------------------------------------------
// tb_sw_pe
// Directed testbench for sw_pe. Stimulus pushes the expected output beat
// (and, at end of stream, the expected max) into queues; a negedge monitor
// pops and compares whenever valid_o/done_o is seen. A second instance with
// SCORE_W=4 exercises saturation.
// ---------------------------------------------------------------------------
module tb_sw_pe;
    import sw_pkg::*;

    localparam int W  = 12;
    localparam int W1 = 4;
    localparam int EW = 1 + 2 + W + W;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    // ---------------- DUT 0 (defaults) ----------------
    logic          load_i, valid_i, last_i;
    logic [1:0]    t_i, s_i;
    logic [W-1:0]  h_i, f_i;
    logic          valid_o, last_o, done_o;
    logic [1:0]    s_o;
    logic [W-1:0]  h_o, f_o, max_o;
    pe_state_t     st0;

    sw_pe u0 (
        .clk(clk), .rst(rst), .load_i(load_i), .t_i(t_i),
        .valid_i(valid_i), .last_i(last_i), .s_i(s_i), .h_i(h_i), .f_i(f_i),
        .valid_o(valid_o), .last_o(last_o), .s_o(s_o), .h_o(h_o), .f_o(f_o),
        .max_o(max_o), .done_o(done_o), .dbg_state(st0)
    );

    // ---------------- DUT 1 (SCORE_W=4) ----------------
    logic          ld1, v1, l1;
    logic [1:0]    t1, s1;
    logic [W1-1:0] h1i, f1i;
    logic          v1o, l1o, done1;
    logic [1:0]    s1o;
    logic [W1-1:0] h1o, f1o, max1;
    pe_state_t     st1;

    sw_pe #(.SCORE_W(W1)) u1 (
        .clk(clk), .rst(rst), .load_i(ld1), .t_i(t1),
        .valid_i(v1), .last_i(l1), .s_i(s1), .h_i(h1i), .f_i(f1i),
        .valid_o(v1o), .last_o(l1o), .s_o(s1o), .h_o(h1o), .f_o(f1o),
        .max_o(max1), .done_o(done1), .dbg_state(st1)
    );

    // ---------------- scoreboard ----------------
    logic [EW-1:0] exp_q[$];
    logic [W-1:0]  exp_max_q[$];
    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (valid_o) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_valid_o", 1, 0);
                end else begin
                    logic [EW-1:0] ent;
                    ent = exp_q.pop_front();
                    check("h_o",    int'(h_o),    int'(ent[W-1:0]));
                    check("f_o",    int'(f_o),    int'(ent[2*W-1:W]));
                    check("s_o",    int'(s_o),    int'(ent[2*W+1:2*W]));
                    check("last_o", int'(last_o), int'(ent[EW-1]));
                end
            end
            if (done_o) begin
                if (exp_max_q.size() == 0) begin
                    check("unexpected_done_o", 1, 0);
                end else begin
                    check("max_o_at_done", int'(max_o), int'(exp_max_q.pop_front()));
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // One valid beat; em >= 0 means a done pulse with that max is expected.
    task automatic send(input logic [1:0] s, input int h, input int f, input logic last,
                        input int eh, input int ef, input int em);
        valid_i = 1'b1;
        s_i     = s;
        h_i     = W'(h);
        f_i     = W'(f);
        last_i  = last;
        exp_q.push_back({last, s, W'(ef), W'(eh)});
        if (last && em >= 0)
            exp_max_q.push_back(W'(em));
        cyc();
        valid_i = 1'b0;
        last_i  = 1'b0;
        load_i  = 1'b0;
    endtask

    task automatic load(input logic [1:0] t);
        load_i = 1'b1;
        t_i    = t;
        cyc();
        load_i = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        load_i = 0; t_i = 0; valid_i = 0; last_i = 0; s_i = 0; h_i = 0; f_i = 0;
        ld1 = 0; t1 = 0; v1 = 0; l1 = 0; s1 = 0; h1i = 0; f1i = 0;

        // Reset state
        #1 rst = 1'b1;
        #2;
        check("rst_valid_o", int'(valid_o), 0);
        check("rst_h_o",     int'(h_o),     0);
        check("rst_max_o",   int'(max_o),   0);
        check("rst_done_o",  int'(done_o),  0);
        check("rst_state",   int'(st0),     int'(ST_IDLE));
        cyc();
        rst = 1'b0;

        // Transparent pass in IDLE: scores forced to 0
        send(SYM_C, 7, 9, 1'b0, 0, 0, -1);
        check("idle_state",  int'(st0),   int'(ST_IDLE));
        check("idle_max_o",  int'(max_o), 0);

        // Basic match: T=A, stream A,C,A
        load(SYM_A);
        check("load_state", int'(st0), int'(ST_READY));
        send(SYM_A, 0, 0, 1'b0, 2, 0, -1);
        send(SYM_C, 0, 0, 1'b0, 0, 0, -1);
        send(SYM_A, 0, 0, 1'b1, 2, 0, 2);
        check("basic_state_after", int'(st0), int'(ST_READY));

        // Horizontal gap
        send(SYM_C, 5, 0, 1'b0, 3, 3, -1);
        send(SYM_C, 0, 3, 1'b1, 4, 2, 4);

        // Bubbles between symbols
        send(SYM_A, 0, 0, 1'b0, 2, 0, -1);
        cyc();
        check("bubble_valid_o", int'(valid_o), 0);
        check("bubble_h_hold",  int'(h_o),     2);
        check("bubble_last_o",  int'(last_o),  0);
        cyc();
        send(SYM_C, 0, 0, 1'b0, 0, 0, -1);
        cyc(); cyc();
        send(SYM_A, 0, 0, 1'b1, 2, 0, 2);

        // Load locking mid-RUN: query stays A
        send(SYM_A, 0, 0, 1'b0, 2, 0, -1);
        check("run_state", int'(st0), int'(ST_RUN));
        load(SYM_T);
        send(SYM_A, 0, 0, 1'b0, 2, 0, -1);
        send(SYM_T, 0, 0, 1'b1, 0, 0, 2);

        // Reload after done, then stream T
        load(SYM_T);
        send(SYM_T, 0, 0, 1'b1, 2, 0, 2);

        // Load together with valid_i is ignored (query stays T)
        load_i = 1'b1; t_i = SYM_A;
        send(SYM_A, 0, 0, 1'b1, 0, 0, 0);
        send(SYM_T, 0, 0, 1'b1, 2, 0, 2);

        // Reset mid-stream
        send(SYM_T, 0, 0, 1'b0, 2, 0, -1);
        cyc();
        rst = 1'b1;
        #1;
        check("midrst_h_o",   int'(h_o),   0);
        check("midrst_s_o",   int'(s_o),   0);
        check("midrst_max_o", int'(max_o), 0);
        check("midrst_state", int'(st0),   int'(ST_IDLE));
        cyc();
        rst = 1'b0;
        send(SYM_T, 4, 6, 1'b0, 0, 0, -1);
        check("postrst_state", int'(st0), int'(ST_IDLE));

        // Saturation on SCORE_W=4 instance: T=G, stream G,G with h_i=15
        ld1 = 1'b1; t1 = SYM_G;
        cyc();
        ld1 = 1'b0;
        v1 = 1'b1; s1 = SYM_G; h1i = 4'd15; f1i = 4'd0;
        cyc();
        check("sat_h_first", int'(h1o), 13);
        check("sat_f_first", int'(f1o), 13);
        l1 = 1'b1;
        cyc();
        v1 = 1'b0; l1 = 1'b0;
        check("sat_h_second", int'(h1o),  15);
        check("sat_max",      int'(max1), 15);
        check("sat_done",     int'(done1), 1);
        cyc();
        check("sat_done_pulse", int'(done1), 0);

        // Drain and confirm every expected beat was observed
        cyc(); cyc();
        check("exp_q_empty",     exp_q.size(),     0);
        check("exp_max_q_empty", exp_max_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog timeout actual=%0t expected=<200000", $time);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/sw_pe.md
Name: sw_pe

Overview:
- One processing element of the Smith-Waterman systolic array.
- Holds one query symbol T. Consumes the reference stream (2-bit symbols plus H/F scores) from its left neighbour, which is the symbol delay buffer or the previous PE.
- Computes one affine-gap cell per valid cycle and forwards the registered symbol, H and F to the next PE.
- Tracks the column maximum for the traceback/max-reduction stage.

Parameters:
- SCORE_W, 12, width of H/E/F/max scores, unsigned.
- MATCH, 2, added on symbol match.
- MISMATCH, 1, subtracted on mismatch.
- GAP_OPEN, 2, gap-open penalty.
- GAP_EXT, 1, gap-extend penalty.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- load_i  in  1  load query symbol from t_i
- t_i  in  2  query symbol (A=00, C=01, G=10, T=11)
- valid_i  in  1  s_i/h_i/f_i/last_i valid this cycle
- last_i  in  1  final reference symbol of the stream
- s_i  in  2  reference symbol
- h_i  in  SCORE_W  H(i,j-1) from left; tie 0 on first PE
- f_i  in  SCORE_W  F(i,j-1) from left; tie 0 on first PE
- valid_o  out  1  registered valid_i
- last_o  out  1  registered last_i
- s_o  out  2  registered s_i
- h_o  out  SCORE_W  H(i,j)
- f_o  out  SCORE_W  F(i,j)
- max_o  out  SCORE_W  max H of current/last stream
- done_o  out  1  one-cycle pulse after last symbol processed

Behaviour:
- Reset: all outputs 0; query, h_diag, h_up, e_reg cleared; state IDLE.
- FSM:
  - IDLE: no query.
  - READY: query held.
  - RUN: stream in progress.
- Transitions:
  - IDLE -load_i-> READY.
  - READY -valid_i-> RUN; if last_i in the same cycle, stay READY.
  - RUN -valid_i&last_i-> READY.
- load_i is accepted only in IDLE/READY with valid_i=0; otherwise ignored, and the query stays locked.
- Per valid cycle in READY/RUN:
  - sub = (s_i==T) ? +MATCH : -MISMATCH.
  - D = clamp(h_diag + sub).
  - E = clamp(max(h_up-GAP_OPEN, e_reg-GAP_EXT)).
  - F = clamp(max(h_i-GAP_OPEN, f_i-GAP_EXT)).
  - H = max(0, D, E, F).
- clamp: floor 0, ceiling 2^SCORE_W-1; compute in SCORE_W+2 signed.
- Register updates on a valid cycle: h_diag<=h_i, h_up<=H, e_reg<=E. The outputs h_o<=H, f_o<=F and s_o/last_o<=inputs take effect with valid_o=1.
- Latency is exactly 1 cycle input to output.
- Bubbles (valid_i=0): internal state holds; valid_o=0, last_o=0; s_o/h_o/f_o hold.
- First valid of a stream (entering from READY): h_diag, h_up, e_reg are treated as 0, and max_o restarts from H of that cycle.
- max_o <= max(max_o, H) on subsequent valid cycles. It holds after the stream until the next stream starts.
- On valid_i&last_i: done_o pulses the next cycle; h_diag, h_up, e_reg clear to 0.
- valid_i in IDLE: transparent pass. s_o/last_o/valid_o are forwarded; h_o=0, f_o=0; max_o and done_o are unaffected.
- Reset mid-stream: immediate return to IDLE; the query must be reloaded.

Decomposition:
- Package sw_pkg: symbol encoding constants, SCORE_W default, scoring parameter defaults, PE state encoding (IDLE/READY/RUN).
- One natural sub-module, sw_cell_calc: combinational D/E/F/H with clamping, shared by later PE variants.
- sw_pe holds the FSM and registers.

Test Plan:
- Basic match (defaults): load T=A; stream A,C,A with h_i=f_i=0, last on 3rd.
  - Expect h_o=2,0,2 one cycle after each input, f_o=0.
  - Expect max_o=2 and done_o pulse after the 3rd output.
- Horizontal gap: T=A, first symbol s=C, h_i=5, f_i=0.
  - Expect f_o=3, h_o=3.
  - Next cycle s=C, h_i=0, f_i=3: expect f_o=2 and h_o=max(0, 5-1=4, E=1, F=2)=4.
- Saturation: SCORE_W=4, T=G, stream G,G with h_i=15,15.
  - Expect 2nd h_o=15, not wrapped, and max_o=15.
- Bubbles: basic-match stream with valid_i low for 2 cycles between symbols.
  - Expect identical h_o sequence, valid_o gaps aligned, no state corruption.
- Load locking:
  - Assert load_i with t_i=T mid-RUN: expect the query unchanged.
  - After done_o, load T, then stream T: expect h_o=2.
- Reset mid-stream: rst during RUN.
  - Expect all outputs 0 and state IDLE.
  - Next valid_i passes through with h_o=0 until a query is loaded.
